sync_hs_tx: RTL and testbench

//  Source side of a multi-channel four-phase req/ack handshake synchroniser, all on one clock.
//  Per channel: buffers up to DEPTH single-cycle events (with DW-bit payload) and replays them one at a time.

---
 rtl/sync_hs_pkg.sv | 14 +
 rtl/sync_hs_tx_ch.sv | 133 +++++++++++++
 rtl/sync_hs_tx.sv | 47 ++++
 tb/tb_sync_hs_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_hs_pkg.sv
// Shared definitions for the sync_hs_tx four-phase handshake source.
// Holds the per-channel FSM encoding and the drop-counter width.
// No ports; imported by sync_hs_tx_ch and sync_hs_tx.
package sync_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for a queued event
        REQ  = 2'd1,    // req_o high, waiting for synchronised ack
        REL  = 2'd2     // req_o low, waiting for synchronised ack to drop
    } hs_state_e;

    localparam int unsigned DROP_CNT_W = 8;

endpackage : sync_hs_pkg

// File: rtl/sync_hs_tx_ch.sv
// One channel of the four-phase req/ack source: event FIFO, ack synchroniser, handshake FSM, drop counter.
// Latency: event accepted into an empty FIFO while IDLE -> req_o high one edge later.
// Backpressure: none upstream; events arriving on a full FIFO (with no same-cycle pop) are dropped and flagged.
// Ports: clk/rst; ev_i/ev_data_i push side; full_o/busy_o status; req_o/data_o/ack_i handshake;
//        drop_o pulse and drop_cnt_o counter (counter built only with SYNC_HS_TX_DROP_CNT_EN defined).
module sync_hs_tx_ch
    import sync_hs_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ev_i,
    input  logic [DW-1:0]         ev_data_i,
    output logic                  full_o,
    output logic                  busy_o,
    output logic                  req_o,
    output logic [DW-1:0]         data_o,
    input  logic                  ack_i,
    output logic                  drop_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         cnt_q;
    logic [AW:0]         cnt_d;
    logic [SYNC_STG-1:0] ack_sync_q;
    logic                ack_s;
    hs_state_e           state_q;
    hs_state_e           state_d;
    logic                req_q;
    logic                req_d;
    logic [DW-1:0]       data_q;
    logic                drop_q;
    logic                pop;
    logic                push;
    logic                full;
    logic                empty;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign ack_s = ack_sync_q[SYNC_STG-1];

    // Handshake FSM. The head is popped on the same edge that raises req,
    // so data_o and req_o move together and data_o is frozen until the next IDLE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = REQ;
                    pop     = 1'b1;
                end
            end
            REQ:     if (ack_s)  state_d = REL;
            REL:     if (!ack_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    // A full FIFO still accepts when the head leaves on the same edge.
    assign push = ev_i && (!full || pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ack_sync_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            ack_sync_q <= {ack_sync_q[SYNC_STG-2:0], ack_i};
            drop_q     <= ev_i && !push;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_data_i;
    end

`ifdef SYNC_HS_TX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (ev_i && !push && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

    assign full_o = full;
    assign busy_o = (state_q != IDLE) || !empty;
    assign req_o  = req_q;
    assign data_o = data_q;
    assign drop_o = drop_q;

endmodule : sync_hs_tx_ch

// File: rtl/sync_hs_tx.sv
// Multi-channel source side of a four-phase req/ack handshake synchroniser; CH independent channels.
// Latency: event into an empty idle channel -> req_o one edge later; ack_i edges seen SYNC_STG+1 edges later.
// Backpressure: per-channel DEPTH-entry queue; overflow drops the event and pulses drop_o.
// Ports: clk, rst (sync, active high), ev_i/ev_data_i, full_o, busy_o, req_o, data_o, ack_i, drop_o, drop_cnt_o.
// Macro SYNC_HS_TX_DROP_CNT_EN builds the saturating per-channel drop counters; otherwise drop_cnt_o is 0.
module sync_hs_tx
    import sync_hs_pkg::*;
#(
    parameter int unsigned CH       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH-1:0]            ev_i,
    input  logic [CH*DW-1:0]         ev_data_i,
    output logic [CH-1:0]            full_o,
    output logic [CH-1:0]            busy_o,
    output logic [CH-1:0]            req_o,
    output logic [CH*DW-1:0]         data_o,
    input  logic [CH-1:0]            ack_i,
    output logic [CH-1:0]            drop_o,
    output logic [CH*DROP_CNT_W-1:0] drop_cnt_o
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sync_hs_tx_ch #(
            .DW       (DW),
            .DEPTH    (DEPTH),
            .SYNC_STG (SYNC_STG)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ev_i       (ev_i[c]),
            .ev_data_i  (ev_data_i[c*DW +: DW]),
            .full_o     (full_o[c]),
            .busy_o     (busy_o[c]),
            .req_o      (req_o[c]),
            .data_o     (data_o[c*DW +: DW]),
            .ack_i      (ack_i[c]),
            .drop_o     (drop_o[c]),
            .drop_cnt_o (drop_cnt_o[c*DROP_CNT_W +: DROP_CNT_W])
        );
    end

endmodule : sync_hs_tx

// File: tb/tb_sync_hs_tx.sv
// Directed bench for sync_hs_tx: single event timing, queueing, overflow, push-on-pop, random acks, reset abort.
module tb_sync_hs_tx;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int SYNC_STG = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     ev_i;
    logic [CH*DW-1:0]  ev_data_i;
    logic [CH-1:0]     full_o;
    logic [CH-1:0]     busy_o;
    logic [CH-1:0]     req_o;
    logic [CH*DW-1:0]  data_o;
    logic [CH-1:0]     ack_i;
    logic [CH-1:0]     drop_o;
    logic [CH*8-1:0]   drop_cnt_o;

    logic [CH-1:0]     auto_en;
    logic [CH-1:0]     ack_auto;
    logic [CH-1:0]     ack_man;
    int                dly [CH];
    logic [CH-1:0]     prev_req;
    logic [DW-1:0]     prev_dat [CH];
    logic [DW-1:0]     dq [CH][$];
    logic [DW-1:0]     eq [CH][$];
    int                drop_seen [CH];
    int                stab_err;
    int                checks;
    int                failures;
    int                exp_cnt;

    assign ack_i = (auto_en & ack_auto) | (~auto_en & ack_man);

    always #5 clk = ~clk;

    sync_hs_tx #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .SYNC_STG(SYNC_STG)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_i       (ev_i),
        .ev_data_i  (ev_data_i),
        .full_o     (full_o),
        .busy_o     (busy_o),
        .req_o      (req_o),
        .data_o     (data_o),
        .ack_i      (ack_i),
        .drop_o     (drop_o),
        .drop_cnt_o (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: outputs sampled 1ns after the edge, monitor and ack responder updated.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (req_o[c] && !prev_req[c]) dq[c].push_back(data_o[c*DW +: DW]);
            if (req_o[c] && prev_req[c] && (data_o[c*DW +: DW] != prev_dat[c])) stab_err++;
            if (drop_o[c]) drop_seen[c]++;
            prev_req[c] = req_o[c];
            prev_dat[c] = data_o[c*DW +: DW];
            if (auto_en[c] && (ack_auto[c] != req_o[c])) begin
                if (dly[c] == 0) begin
                    ack_auto[c] = req_o[c];
                    dly[c] = int'($urandom_range(0, 20));
                end else begin
                    dly[c]--;
                end
            end
        end
    endtask

    task automatic clear_logs();
        for (int c = 0; c < CH; c++) begin
            dq[c].delete();
            eq[c].delete();
            drop_seen[c] = 0;
        end
        stab_err = 0;
    endtask

    task automatic push1(input int c, input logic [DW-1:0] d);
        ev_i[c] = 1'b1;
        ev_data_i[c*DW +: DW] = d;
        tick();
        ev_i[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c, input int bound);
        int n;
        n = 0;
        while ((busy_o[c] || ack_i[c]) && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) chk("drain_timeout", 32'(c), 32'hFFFF_FFFF);
    endtask

    task automatic chk_seq(input string tag, input int c, input logic [DW-1:0] base, input int n);
        int bad;
        bad = 0;
        chk({tag, "_len"}, 32'(dq[c].size()), 32'(n));
        for (int i = 0; i < n && i < dq[c].size(); i++)
            if (dq[c][i] != base + DW'(i)) bad++;
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; ev_i = '0; ev_data_i = '0;
        auto_en = '0; ack_auto = '0; ack_man = '0; prev_req = '0;
        for (int c = 0; c < CH; c++) begin dly[c] = 0; prev_dat[c] = '0; end
        clear_logs();
        tick(); tick();
        chk("rst_req", 32'(req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_drop", 32'(drop_o), 32'd0);
        chk("rst_dcnt", drop_cnt_o, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single event on ch0, ack three cycles after req
        push1(0, 8'hA5);
        chk("t1_req_accept", 32'(req_o[0]), 32'd0);
        chk("t1_busy_accept", 32'(busy_o[0]), 32'd1);
        tick();
        chk("t1_req_up", 32'(req_o[0]), 32'd1);
        chk("t1_data", 32'(data_o[7:0]), 32'hA5);
        tick(); tick(); tick();
        ack_man[0] = 1'b1;
        tick(); chk("t1_req_ack1", 32'(req_o[0]), 32'd1);
        tick(); chk("t1_req_ack2", 32'(req_o[0]), 32'd1);
        tick(); chk("t1_req_ack3", 32'(req_o[0]), 32'd0);
        chk("t1_data_hold", 32'(data_o[7:0]), 32'hA5);
        ack_man[0] = 1'b0;
        tick(); tick();
        chk("t1_busy_rel", 32'(busy_o[0]), 32'd1);
        tick();
        chk("t1_busy_clr", 32'(busy_o[0]), 32'd0);
        chk("t1_stable", 32'(stab_err), 32'd0);

        // 2: five back-to-back on ch1, ack withheld, then released
        clear_logs();
        for (int i = 1; i <= 5; i++) push1(1, DW'(i));
        chk("t2_full", 32'(full_o[1]), 32'd1);
        chk("t2_req", 32'(req_o[1]), 32'd1);
        chk("t2_data", 32'(data_o[15:8]), 32'h01);
        auto_en[1] = 1'b1;
        wait_idle(1, 2000);
        chk_seq("t2", 1, 8'h01, 5);
        chk("t2_drops", 32'(drop_seen[1]), 32'd0);

        // 3: six events on ch2 with ack stuck low, sixth dropped
        clear_logs();
        for (int i = 1; i <= 6; i++) push1(2, DW'(8'h20 + i));
        chk("t3_drop_pulse", 32'(drop_o[2]), 32'd1);
`ifdef SYNC_HS_TX_DROP_CNT_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("t3_dcnt", 32'(drop_cnt_o[23:16]), 32'(exp_cnt));
        tick();
        chk("t3_drop_end", 32'(drop_o[2]), 32'd0);
        chk("t3_drop_count", 32'(drop_seen[2]), 32'd1);
        auto_en[2] = 1'b1;
        wait_idle(2, 2000);
        chk_seq("t3", 2, 8'h21, 5);

        // 4: push while full on the IDLE->REQ pop edge of ch3
        clear_logs();
        for (int i = 1; i <= 5; i++) push1(3, DW'(8'h30 + i));
        ack_man[3] = 1'b1;
        tick(); tick(); tick();
        chk("t4_req_fall", 32'(req_o[3]), 32'd0);
        ack_man[3] = 1'b0;
        tick(); tick(); tick();
        chk("t4_full_idle", 32'(full_o[3]), 32'd1);
        push1(3, 8'h36);
        chk("t4_req_up", 32'(req_o[3]), 32'd1);
        chk("t4_data", 32'(data_o[31:24]), 32'h32);
        chk("t4_full_keep", 32'(full_o[3]), 32'd1);
        chk("t4_no_drop", 32'(drop_o[3]), 32'd0);
        auto_en[3] = 1'b1;
        wait_idle(3, 2000);
        chk_seq("t4", 3, 8'h31, 6);
        chk("t4_drops", 32'(drop_seen[3]), 32'd0);

        // 5: all channels, random payloads and ack delays
        clear_logs();
        auto_en = '1;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < CH; c++) begin
                ev_i[c] = 1'b0;
                if (!full_o[c] && ($urandom_range(0, 2) == 0)) begin
                    ev_i[c] = 1'b1;
                    ev_data_i[c*DW +: DW] = DW'($urandom);
                    eq[c].push_back(ev_data_i[c*DW +: DW]);
                end
            end
            tick();
        end
        ev_i = '0;
        for (int c = 0; c < CH; c++) wait_idle(c, 5000);
        for (int c = 0; c < CH; c++) begin
            int bad;
            bad = 0;
            chk("t5_len", 32'(dq[c].size()), 32'(eq[c].size()));
            for (int i = 0; i < eq[c].size() && i < dq[c].size(); i++)
                if (dq[c][i] != eq[c][i]) bad++;
            chk("t5_order", 32'(bad), 32'd0);
            chk("t5_drops", 32'(drop_seen[c]), 32'd0);
        end
        chk("t5_stable", 32'(stab_err), 32'd0);

        // 6: reset with ch3 in REQ and two queued
        clear_logs();
        auto_en[3] = 1'b0;
        ack_man[3] = 1'b0;
        push1(3, 8'h61); push1(3, 8'h62); push1(3, 8'h63);
        chk("t6_pre_req", 32'(req_o[3]), 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_req", 32'(req_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_full", 32'(full_o), 32'd0);
        chk("t6_dcnt", drop_cnt_o, 32'd0);
        rst = 1'b0;
        tick();
        clear_logs();
        auto_en[3] = 1'b1;
        push1(3, 8'h6A);
        tick();
        chk("t6_req_again", 32'(req_o[3]), 32'd1);
        wait_idle(3, 2000);
        chk_seq("t6", 3, 8'h6A, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_hs_tx
